// File: rtl/fetch_decode_unit_if.sv
// fetch_decode_unit_if: instruction ROM and data memory read bus
// master (core): drives rom_addr/mem_addr, receives rom_data/mem_data
// slave (memories): returns combinational read data for the presented addresses
interface fetch_decode_unit_if #(parameter int PC_W = 4, parameter int OPR_W = 5);
    logic [PC_W-1:0]  rom_addr;
    logic [7:0]       rom_data;
    logic [OPR_W-1:0] mem_addr;
    logic [7:0]       mem_data;
    modport master(output rom_addr, mem_addr, input rom_data, mem_data);
    modport slave(input rom_addr, mem_addr, output rom_data, mem_data);
endinterface

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: 3-state fetch/decode/execute core with 8-bit accumulator
// clk/rst: clock, sync active-high reset; en: run enable (freeze when low)
// bus: ROM and data memory read bus; acc/pc/ir/zero/carry/state/instr_done: registered status
module fetch_decode_unit #(parameter int PC_W = 4, parameter int OPR_W = 5) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    fetch_decode_unit_if.master bus,
    output logic [7:0]          acc,
    output logic [PC_W-1:0]     pc,
    output logic [7:0]          ir,
    output logic                zero,
    output logic                carry,
    output logic [1:0]          state,
    output logic                instr_done
);
    typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, EXECUTE = 2'd2} state_t;
    state_t st, st_nx;
    logic [7:0] opr, res;
    logic [8:0] sum, diff;
    logic       cy;
    logic [2:0] op;
    assign op           = ir[7:5];
    assign bus.rom_addr = pc;
    assign bus.mem_addr = ir[OPR_W-1:0];
    assign state        = st;
    always_ff @(posedge clk)
        st <= rst ? FETCH : st_nx;
    always_comb begin
        st_nx = st;
        if (en) st_nx = st == FETCH ? DECODE : st == DECODE ? EXECUTE : FETCH;
    end
    // zero-extended subtract leaves the unsigned borrow in bit 8
    always_comb begin
        sum  = {1'b0, acc} + {1'b0, opr};
        diff = {1'b0, acc} - {1'b0, opr};
        res  = op == 3'd0 ? sum[7:0] : op == 3'd1 ? diff[7:0] : op == 3'd2 ? acc & opr :
               op == 3'd3 ? acc | opr : op == 3'd4 ? ~acc : op == 3'd5 ? acc ^ opr : opr;
        cy   = op == 3'd0 ? sum[8] : op == 3'd1 ? diff[8] : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            pc         <= '0;
            ir         <= '0;
            opr        <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            instr_done <= en && st == EXECUTE;
            if (en) begin
                case (st)
                    FETCH: begin
                        ir <= bus.rom_data;
                        pc <= pc + 1'b1;
                    end
                    DECODE: opr <= bus.mem_data;
                    EXECUTE: begin
                        if (op == 3'd7) pc <= ir[PC_W-1:0];
                        else begin
                            acc   <= res;
                            carry <= cy;
                            zero  <= res == 8'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: scoreboard bench for fetch_decode_unit
module tb_fetch_decode_unit;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [7:0] acc, ir;
    logic [3:0] pc;
    logic       zero, carry, instr_done;
    logic [1:0] state;
    logic [7:0] rom [16];
    logic [7:0] mem [32];
    int tests = 0, fails = 0;

    fetch_decode_unit_if #(.PC_W(4), .OPR_W(5)) bus();

    fetch_decode_unit #(.PC_W(4), .OPR_W(5)) dut (
        .clk(clk), .rst(rst), .en(en), .bus(bus.master),
        .acc(acc), .pc(pc), .ir(ir), .zero(zero), .carry(carry),
        .state(state), .instr_done(instr_done)
    );

    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.mem_data = mem[bus.mem_addr];

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] acc;
        logic       z;
        logic       c;
        logic [3:0] pc;
        logic [7:0] ir;
    } exp_t;
    exp_t q[$];
    exp_t e_mon;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic z, input logic c, input logic [3:0] p, input logic [7:0] i);
        q.push_back('{acc: a, z: z, c: c, pc: p, ir: i});
    endtask

    always @(negedge clk) begin
        if (instr_done === 1'b1 && q.size() > 0) begin
            e_mon = q.pop_front();
            chk("sb_acc", acc, e_mon.acc);
            chk("sb_zero", zero, e_mon.z);
            chk("sb_carry", carry, e_mon.c);
            chk("sb_pc", pc, e_mon.pc);
            chk("sb_ir", ir, e_mon.ir);
        end
    end

    task automatic clear_mems();
        foreach (rom[i]) rom[i] = 8'h00;
        foreach (mem[i]) mem[i] = 8'h00;
    endtask

    task automatic chk_reset(input string n);
        chk({n, "_acc"}, acc, 8'h00);
        chk({n, "_pc"}, pc, 4'h0);
        chk({n, "_ir"}, ir, 8'h00);
        chk({n, "_zero"}, zero, 1'b0);
        chk({n, "_carry"}, carry, 1'b0);
        chk({n, "_state"}, state, 2'd0);
        chk({n, "_done"}, instr_done, 1'b0);
        chk({n, "_rom_addr"}, bus.rom_addr, 4'h0);
        chk({n, "_mem_addr"}, bus.mem_addr, 5'h00);
    endtask

    task automatic do_reset(input string n);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk); #1;
        chk_reset(n);
        rst = 1'b0;
    endtask

    task automatic wait_q(input int target);
        int n = 0;
        while (q.size() > target && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > target) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d entries left, expected %0d", q.size(), target);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nd;
        clear_mems();

        // full program
        rom[0] = 8'h00; rom[1] = 8'h21; rom[2] = 8'h42; rom[3] = 8'h63;
        rom[4] = 8'h84; rom[5] = 8'hA4; rom[6] = 8'h00; rom[7] = 8'hE0;
        mem[0] = 8'h05; mem[1] = 8'h03; mem[2] = 8'h0F; mem[3] = 8'h30; mem[4] = 8'hFF;
        do_reset("rst_prog");
        push(8'h05, 0, 0, 4'd1, 8'h00);
        push(8'h02, 0, 0, 4'd2, 8'h21);
        push(8'h02, 0, 0, 4'd3, 8'h42);
        push(8'h32, 0, 0, 4'd4, 8'h63);
        push(8'hCD, 0, 0, 4'd5, 8'h84);
        push(8'h32, 0, 0, 4'd6, 8'hA4);
        push(8'h37, 0, 0, 4'd7, 8'h00);
        push(8'h37, 0, 0, 4'd0, 8'hE0);
        wait_q(0);
        #1;
        chk("jmp_refetch_ir", ir, 8'h00);
        chk("jmp_refetch_pc", pc, 4'd1);

        // flags
        clear_mems();
        rom[0] = 8'hC0; rom[1] = 8'h01; rom[2] = 8'h21;
        mem[0] = 8'hFF; mem[1] = 8'h01;
        do_reset("rst_flags");
        push(8'hFF, 0, 0, 4'd1, 8'hC0);
        push(8'h00, 1, 1, 4'd2, 8'h01);
        push(8'hFF, 0, 1, 4'd3, 8'h21);
        wait_q(0);

        // reset during DECODE of SUB
        do_reset("rst_midop_pre");
        push(8'hFF, 0, 0, 4'd1, 8'hC0);
        push(8'h00, 1, 1, 4'd2, 8'h01);
        wait_q(0);
        #1;
        chk("midop_in_decode", state, 2'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset("midop");
        push(8'hFF, 0, 0, 4'd1, 8'hC0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midop_done_e1", instr_done, 1'b0);
        @(posedge clk); #1;
        chk("midop_done_e2", instr_done, 1'b0);
        @(posedge clk); #1;
        chk("midop_done_e3", instr_done, 1'b1);
        wait_q(0);

        // enable stall during EXECUTE of ADD
        clear_mems();
        rom[0] = 8'hC0; rom[1] = 8'h01;
        mem[0] = 8'h05; mem[1] = 8'h03;
        do_reset("rst_stall");
        push(8'h05, 0, 0, 4'd1, 8'hC0);
        push(8'h08, 0, 0, 4'd2, 8'h01);
        wait_q(1);
        #1;
        chk("stall_decode", state, 2'd1);
        @(posedge clk); #1;
        chk("stall_execute", state, 2'd2);
        en = 1'b0;
        nd = 0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_state", state, 2'd2);
            chk("stall_acc", acc, 8'h05);
            nd += int'(instr_done);
        end
        en = 1'b1;
        @(posedge clk); #1;
        chk("stall_resume_acc", acc, 8'h08);
        chk("stall_resume_state", state, 2'd0);
        nd += int'(instr_done);
        repeat (2) begin
            @(posedge clk); #1;
            nd += int'(instr_done);
        end
        chk("stall_done_count", nd, 1);
        wait_q(0);

        // jump to F then pc wraps on fetch
        clear_mems();
        rom[0] = 8'hEF; rom[15] = 8'hC1;
        mem[1] = 8'hAA;
        do_reset("rst_wrap");
        push(8'h00, 0, 0, 4'hF, 8'hEF);
        push(8'hAA, 0, 0, 4'h0, 8'hC1);
        wait_q(0);

        // JMP ignores ir[4], flags preserved
        clear_mems();
        rom[0] = 8'hC0; rom[1] = 8'h01; rom[2] = 8'hF3; rom[3] = 8'hC2;
        mem[0] = 8'hFF; mem[1] = 8'h01; mem[2] = 8'h77;
        do_reset("rst_jmp4");
        push(8'hFF, 0, 0, 4'd1, 8'hC0);
        push(8'h00, 1, 1, 4'd2, 8'h01);
        push(8'h00, 1, 1, 4'd3, 8'hF3);
        push(8'h77, 0, 0, 4'd4, 8'hC2);
        wait_q(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Sequencing and execution core that consumes the 8-bit instruction ROM: it drives the 4-bit ROM address from its program counter, latches the returned instruction, decodes the 3-bit opcode and 5-bit operand, reads the data memory, and updates an 8-bit accumulator and flags. It is the reading end of the ROM interface and sits between the instruction ROM, the data memory and the top-level CPU wrapper. It uses a 3-state FETCH/DECODE/EXECUTE machine, so every instruction takes exactly 3 enabled cycles.

## Interface
- `PC_W`, default 4: program counter and ROM address width.
- `OPR_W`, default 5: operand field width, which is also the data memory address width.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: run enable; while low the unit freezes.
- `rom_addr`  out  PC_W: instruction ROM address, equal to `pc`.
- `rom_data`  in  8: instruction from the ROM; combinational, valid in the same cycle.
- `mem_addr`  out  OPR_W: data memory address, equal to `ir[4:0]`.
- `mem_data`  in  8: data memory read value; combinational, valid in the same cycle.
- `acc`  out  8: accumulator.
- `pc`  out  PC_W: program counter.
- `ir`  out  8: instruction register.
- `zero`  out  1: result-zero flag.
- `carry`  out  1: carry/borrow flag.
- `state`  out  2: FETCH=0, DECODE=1, EXECUTE=2.
- `instr_done`  out  1: one-cycle pulse after each EXECUTE.

## Operation
- **Instruction format:** `ir[7:5]` is the opcode and `ir[4:0]` is the operand.
- **Opcodes:**
  - 000 ADD: acc ← acc + M.
  - 001 SUB: acc ← acc − M.
  - 010 AND: acc ← acc & M.
  - 011 OR: acc ← acc | M.
  - 100 NOT: acc ← ~acc; operand ignored.
  - 101 XOR: acc ← acc ^ M.
  - 110 LDA: acc ← M.
  - 111 JMP: pc ← `ir[3:0]`; `ir[4]` ignored.
- M is the operand register `opr`, latched from `mem_data` during DECODE.
- **FETCH:** `ir` ← `rom_data`, `pc` ← `pc`+1 (mod 16, so 15 wraps to 0), then go to DECODE.
- **DECODE:** `opr` ← `mem_data` (the address is `ir[4:0]`), then go to EXECUTE.
- **EXECUTE:** apply the opcode, update the flags, go to FETCH, set `instr_done` for the next cycle.
- **Arithmetic and flags:**
  - ADD: 9-bit sum; `carry` ← bit 8, `acc` ← bits 7:0.
  - SUB: `carry` ← 1 if acc < M (unsigned borrow); `acc` ← difference mod 256.
  - AND/OR/NOT/XOR/LDA: `carry` ← 0.
  - All ALU ops and LDA: `zero` ← (new acc == 0).
  - JMP leaves `acc`, `zero` and `carry` unchanged. A JMP target overrides the increment done in FETCH.
- **Reset values** (after the first `clk` edge with `rst`=1): `acc`=0x00, `pc`=0, `ir`=0x00, `opr`=0x00, `zero`=0, `carry`=0, `state`=FETCH, `instr_done`=0.
  - Because `rom_addr`=`pc` and `mem_addr`=`ir[4:0]`, both addresses also read 0.
- **Reset mid-instruction:** aborts the instruction with no partial update; all registers take their reset values on that edge.
- **`rst` and `en` together:** `rst` has priority over `en`.
- **`en`=0:**
  - No register changes, the state holds and `instr_done` is 0.
  - Resuming continues from the held state with no lost or repeated step.
  - `rom_addr` and `mem_addr` keep tracking `pc` and `ir`.
- **Undefined ROM locations** (beyond the populated program) are executed as whatever value is read; the unit does not trap.

## Timing
- Each instruction is 3 enabled cycles.
- `ir` is visible 1 cycle after FETCH.
- `acc` and the flags are visible on the edge that ends EXECUTE.
- `instr_done` is high in the cycle after EXECUTE, coincident with the next FETCH.
- After reset release the first FETCH is the first enabled cycle; the first `instr_done` comes 3 enabled edges later.
- JMP: the instruction at the target is fetched in the cycle immediately after EXECUTE; there are no bubbles.
- All outputs are registered or are direct copies of registers; there is no combinational path from `rom_data` or `mem_data` to any output.

## Test plan
- **Full program.**
  - Stimulus: ROM 00,21,42,63,84,A4,00,E0; data memory m0=05, m1=03, m2=0F, m3=30, m4=FF; `en`=1 throughout.
  - Required response: `acc` after each `instr_done` is 05, 02, 02, 32, CD, 32, 37, 37.
  - After the JMP, `pc`=0 and the next fetched `ir`=00.
- **Flags.**
  - Stimulus: LDA m(=FF) then ADD m(=01).
  - Required response: `acc`=00, `carry`=1, `zero`=1.
  - Stimulus: then SUB m(=01).
  - Required response: `acc`=FF, `carry`=1, `zero`=0.
- **Reset mid-op.**
  - Stimulus: assert `rst` in the DECODE state of the SUB instruction.
  - Required response: next edge gives `acc`=00, `pc`=0, `state`=0, `instr_done`=0; the first `instr_done` comes 3 edges after `rst` falls.
- **Enable stall.**
  - Stimulus: drop `en` for 5 cycles during EXECUTE of ADD.
  - Required response: `acc` and `state` are frozen; the result appears on the first enabled edge; exactly one `instr_done` is produced.
- **PC wrap.**
  - Stimulus: JMP to 0xF, where ROM[F]=C1 (LDA m1).
  - Required response: after the FETCH at address F, `pc`=0; `acc`=m1.
- **JMP ignores `ir[4]`.**
  - Stimulus: instruction F3.
  - Required response: `pc`=3; flags and `acc` unchanged.
